otter_if_stage: RTL and testbench

Instruction-fetch stage of the pipelined OTTER core. It owns the fetch PC, drives the instruction port of the shared Memory (port 1, synchronous read, 1-cycle latency) and produces the IF/DE pipeline register consumed by decode. It supports decode stalls through a one-entry skid buffer, so no instruction is lost or duplicated. It also supports redirects from execute (branch, jump or trap target), which flush the instruction in decode.

---
 rtl/otter_pkg.sv | 24 ++
 rtl/otter_if_skid.sv | 53 +++++
 rtl/otter_if_stage.sv | 127 ++++++++++++
 tb/tb_otter_if_stage.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/otter_pkg.sv
// Shared OTTER definitions: the NOP encoding, the default reset PC and the IF/DE
// pipeline register layout.
package otter_pkg;

   localparam logic [31:0] OTTER_NOP      = 32'h0000_0013;
   localparam logic [31:0] OTTER_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [31:0] ir;
   } if_de_t;

   // Decode slot after a flush: no instruction, NOP in IR, PC fields kept as given.
   function automatic if_de_t if_de_flush(input if_de_t cur);
      if_de_t r;
      r       = cur;
      r.valid = 1'b0;
      r.ir    = OTTER_NOP;
      return r;
   endfunction

endpackage

// File: rtl/otter_if_skid.sv
// One-entry skid buffer holding the response that arrived while decode was stalled.
// Priority is clear > load > drain.
module otter_if_skid
   import otter_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        drain,
   input  logic        clear,
   input  logic [31:0] load_pc,
   input  logic [31:0] load_ir,
   output logic        valid,
   output logic [31:0] pc,
   output logic [31:0] ir
);

   logic        valid_q, valid_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;

   always_comb begin
      valid_d = valid_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      if (clear) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d = 1'b1;
         pc_d    = load_pc;
         ir_d    = load_ir;
      end else if (drain) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         pc_q    <= 32'h0;
         ir_q    <= OTTER_NOP;
      end else begin
         valid_q <= valid_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   assign valid = valid_q;
   assign pc    = pc_q;
   assign ir    = ir_q;

endmodule

// File: rtl/otter_if_stage.sv
// OTTER instruction-fetch stage: fetch PC, memory port 1 requests, stall skid and
// IF/DE register. Optional perf counters are enabled with macro OTTER_IF_PERF_EN.
module otter_if_stage
   import otter_pkg::*;
#(
   parameter logic [31:0] RESET_PC = OTTER_RESET_PC,
   parameter int          ADDR_W   = 14
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              STALL,
   input  logic              REDIRECT,
   input  logic [31:0]       REDIRECT_PC,
   output logic              MEM_RDEN1,
   output logic [ADDR_W-1:0] MEM_ADDR1,
   input  logic [31:0]       MEM_DOUT1,
   output logic              DE_VALID,
   output logic [31:0]       DE_PC,
   output logic [31:0]       DE_PC4,
   output logic [31:0]       DE_IR
`ifdef OTTER_IF_PERF_EN
   ,
   output logic [31:0]       PERF_FETCH,
   output logic [31:0]       PERF_BUBBLE
`endif
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] rsp_pc_q, rsp_pc_d;
   logic        rsp_valid_q, rsp_valid_d;
   if_de_t      de_q, de_d;

   logic [31:0] fa;
   logic        req;
   logic        skid_load, skid_drain, skid_clear, skid_valid;
   logic [31:0] skid_pc, skid_ir;

   otter_if_skid u_skid (
      .clk     (CLK),
      .rst     (RESET),
      .load    (skid_load),
      .drain   (skid_drain),
      .clear   (skid_clear),
      .load_pc (rsp_pc_q),
      .load_ir (MEM_DOUT1),
      .valid   (skid_valid),
      .pc      (skid_pc),
      .ir      (skid_ir)
   );

   always_comb begin
      fa          = REDIRECT ? (REDIRECT_PC & 32'hFFFF_FFFC) : pc_q;
      req         = !RESET && (REDIRECT || !STALL);
      pc_d        = req ? fa + 32'd4 : pc_q;
      rsp_valid_d = req;
      rsp_pc_d    = req ? fa : rsp_pc_q;
      skid_load   = 1'b0;
      skid_drain  = 1'b0;
      skid_clear  = 1'b0;
      de_d        = de_q;
      if (REDIRECT) begin
         // Flush beats stall: the old response and any skid entry are dropped.
         de_d       = if_de_flush(de_q);
         skid_clear = 1'b1;
      end else if (STALL) begin
         skid_load = rsp_valid_q;
      end else if (skid_valid) begin
         de_d.valid = 1'b1;
         de_d.pc    = skid_pc;
         de_d.pc4   = skid_pc + 32'd4;
         de_d.ir    = skid_ir;
         skid_drain = 1'b1;
      end else begin
         de_d.valid = rsp_valid_q;
         de_d.pc    = rsp_pc_q;
         de_d.pc4   = rsp_pc_q + 32'd4;
         de_d.ir    = rsp_valid_q ? MEM_DOUT1 : OTTER_NOP;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         pc_q        <= RESET_PC;
         rsp_pc_q    <= 32'h0;
         rsp_valid_q <= 1'b0;
         de_q        <= '{valid: 1'b0, pc: 32'h0, pc4: 32'h0, ir: OTTER_NOP};
      end else begin
         pc_q        <= pc_d;
         rsp_pc_q    <= rsp_pc_d;
         rsp_valid_q <= rsp_valid_d;
         de_q        <= de_d;
      end
   end

   assign MEM_RDEN1 = req;
   assign MEM_ADDR1 = fa[ADDR_W+1:2];
   assign DE_VALID  = de_q.valid;
   assign DE_PC     = de_q.pc;
   assign DE_PC4    = de_q.pc4;
   assign DE_IR     = de_q.ir;

`ifdef OTTER_IF_PERF_EN
   logic [31:0] perf_fetch_q, perf_fetch_d;
   logic [31:0] perf_bubble_q, perf_bubble_d;

   always_comb begin
      perf_fetch_d  = perf_fetch_q + {31'h0, req};
      perf_bubble_d = perf_bubble_q + {31'h0, (!de_d.valid && !STALL)};
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         perf_fetch_q  <= 32'h0;
         perf_bubble_q <= 32'h0;
      end else begin
         perf_fetch_q  <= perf_fetch_d;
         perf_bubble_q <= perf_bubble_d;
      end
   end

   assign PERF_FETCH  = perf_fetch_q;
   assign PERF_BUBBLE = perf_bubble_q;
`else
   // Without perf counters the fetch path is unchanged.
`endif

endmodule

// File: tb/tb_otter_if_stage.sv
// Directed bench for otter_if_stage: fetch stream, stall skid, redirect flush,
// PC wrap and asynchronous reset during a full skid.
module tb_otter_if_stage;

   localparam int ADDR_W = 14;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic              clk;
   logic              rst;
   logic              stall;
   logic              redirect;
   logic [31:0]       redirect_pc;
   logic              mem_rden1;
   logic [ADDR_W-1:0] mem_addr1;
   logic [31:0]       mem_dout1;
   logic              de_valid;
   logic [31:0]       de_pc;
   logic [31:0]       de_pc4;
   logic [31:0]       de_ir;
`ifdef OTTER_IF_PERF_EN
   logic [31:0]       perf_fetch;
   logic [31:0]       perf_bubble;
`endif

   int n_checks;
   int n_fail;

   otter_if_stage #(.RESET_PC(32'h0), .ADDR_W(ADDR_W)) dut (
      .CLK         (clk),
      .RESET       (rst),
      .STALL       (stall),
      .REDIRECT    (redirect),
      .REDIRECT_PC (redirect_pc),
      .MEM_RDEN1   (mem_rden1),
      .MEM_ADDR1   (mem_addr1),
      .MEM_DOUT1   (mem_dout1),
      .DE_VALID    (de_valid),
      .DE_PC       (de_pc),
      .DE_PC4      (de_pc4),
      .DE_IR       (de_ir)
`ifdef OTTER_IF_PERF_EN
      ,
      .PERF_FETCH  (perf_fetch),
      .PERF_BUBBLE (perf_bubble)
`endif
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory port 1: word i holds 32'h1000_0000 + i, one-cycle read latency
   initial mem_dout1 = 32'h0;
   always @(posedge clk) begin
      if (mem_rden1) mem_dout1 <= 32'h1000_0000 + 32'(mem_addr1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_de(input string tag, input logic v, input logic [31:0] pc,
                           input logic [31:0] pc4, input logic [31:0] ir);
      check({tag, "_valid"}, {31'h0, de_valid}, {31'h0, v});
      check({tag, "_pc"},    de_pc,  pc);
      check({tag, "_pc4"},   de_pc4, pc4);
      check({tag, "_ir"},    de_ir,  ir);
   endtask

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      rst         = 1'b1;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      tick();
      tick();
      check_de("reset", 1'b0, 32'h0, 32'h0, NOP);
      check("reset_rden", {31'h0, mem_rden1}, 32'h0);

      // 1: fetch stream after reset release
      rst = 1'b0;
      tick();
      tick();
      check_de("first", 1'b1, 32'h0, 32'h4, 32'h1000_0000);
      tick();
      check_de("seq4", 1'b1, 32'h4, 32'h8, 32'h1000_0001);
      tick();
      check_de("seq8", 1'b1, 32'h8, 32'hC, 32'h1000_0002);

      // 2: three-cycle stall while DE_PC=8
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_de("stall_hold", 1'b1, 32'h8, 32'hC, 32'h1000_0002);
      end
      stall = 1'b0;
      tick();
      check_de("skid_out", 1'b1, 32'hC, 32'h10, 32'h1000_0003);
      tick();
      check_de("after_skid", 1'b1, 32'h10, 32'h14, 32'h1000_0004);

      // 3: redirect to 0x100 while DE_PC=0x10
      redirect    = 1'b1;
      redirect_pc = 32'h100;
      tick();
      redirect = 1'b0;
      check_de("flush", 1'b0, 32'h10, 32'h14, NOP);
      tick();
      check_de("tgt100", 1'b1, 32'h100, 32'h104, 32'h1000_0040);
      tick();
      check_de("tgt104", 1'b1, 32'h104, 32'h108, 32'h1000_0041);

      // 4: fill the skid, then redirect under stall
      stall = 1'b1;
      tick();
      check_de("fill_hold", 1'b1, 32'h104, 32'h108, 32'h1000_0041);
      redirect    = 1'b1;
      redirect_pc = 32'h203;
      tick();
      redirect = 1'b0;
      stall    = 1'b0;
      check_de("flush_stall", 1'b0, 32'h104, 32'h108, NOP);
      tick();
      check_de("tgt200", 1'b1, 32'h200, 32'h204, 32'h1000_0080);
      tick();
      check_de("tgt204", 1'b1, 32'h204, 32'h208, 32'h1000_0081);

      // 5: wrap at the top of the address space
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect = 1'b0;
      check("wrap_flush_valid", {31'h0, de_valid}, 32'h0);
      tick();
      check_de("wrap_top", 1'b1, 32'hFFFF_FFFC, 32'h0, 32'h1000_3FFF);
      tick();
      check_de("wrap_zero", 1'b1, 32'h0, 32'h4, 32'h1000_0000);

      // 6: asynchronous reset mid-stall with a full skid
      stall = 1'b1;
      tick();
      check_de("pre_rst_hold", 1'b1, 32'h0, 32'h4, 32'h1000_0000);
      #2;
      rst = 1'b1;
      #1;
      check("async_valid", {31'h0, de_valid}, 32'h0);
      check("async_ir", de_ir, NOP);
      check("async_rden", {31'h0, mem_rden1}, 32'h0);
      tick();
      rst   = 1'b0;
      stall = 1'b0;
      tick();
      check("post_rst_bubble", {31'h0, de_valid}, 32'h0);
      tick();
      check_de("post_rst_first", 1'b1, 32'h0, 32'h4, 32'h1000_0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
